game_input_bank: RTL
====================

# game_input_bank

Parametrised multi-channel input conditioner for the game controller path, generalising the fixed six-button handler. Every raw button is polarity-normalised, two-flop synchronised and debounced entirely in the clk_game domain. Each channel then produces a clean level plus one-cycle press, release and auto-repeat strobes. It sits between the board pins (onboard keys and GPIO) and the player/game FSMs, which consume only the strobes and levels.

## Interface
- N_CH, 6: number of button channels.
- ACTIVE_LOW_MASK, 6'b000111: bit i = 1 means raw_in[i] is active-low (inverted on entry).
- DB_CYCLES, 4: consecutive clk_game cycles a synchronised value must differ from level before level flips; ≥1.
- REPEAT_MASK, 6'b011011: bit i = 1 enables auto-repeat on channel i.
- REPEAT_DELAY, 20: cycles from the press strobe to the first auto-repeat strobe; ≥1.
- REPEAT_RATE, 5: cycles between subsequent auto-repeat strobes; ≥1.
- clk_game  in  1  game clock; all state is in this domain.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous clear of debounce/repeat state (sync flops untouched).
- raw_in  in  N_CH  asynchronous raw buttons, per-bit polarity per ACTIVE_LOW_MASK.
- level  out  N_CH  debounced active-high button state.
- press  out  N_CH  one-cycle strobe when level goes 0→1.
- release  out  N_CH  one-cycle strobe when level goes 1→0.
- rpt  out  N_CH  press strobe OR auto-repeat strobe (masked channels); equals press on unmasked channels.

## Operation
Reset: asynchronous, active-high; clock: clk_game.
- Per channel: norm = raw_in[i] XOR ACTIVE_LOW_MASK[i]; s1 <= norm; s2 <= s1.
- Debounce counter dbc, width max(1, clog2(DB_CYCLES)):
  - If s2 == level: dbc <= 0.
  - Else if dbc == DB_CYCLES-1: level <= s2, dbc <= 0.
  - Else: dbc <= dbc+1.
- A mismatch shorter than DB_CYCLES cycles resets dbc and never changes level.
- press/release are registered and asserted for exactly the cycle in which level first shows its new value.
- Repeat FSM (masked channels), states IDLE, ARM, RUN; counter rc, width clog2(max(REPEAT_DELAY, REPEAT_RATE)+1):
  - IDLE: on the level 0→1 update → ARM, rc <= 0.
  - ARM: rc++; the cycle REPEAT_DELAY after press → rpt pulse, RUN, rc <= 0.
  - RUN: the cycle REPEAT_RATE after the last pulse → rpt pulse, rc <= 0.
  - Any 1→0 level update → IDLE immediately; no rpt on release.
- rpt = press | auto pulse.
- flush (synchronous, highest priority after reset): level, dbc, rc, press, release and rpt all go to 0; FSM → IDLE.
  - A button still held after flush re-debounces and produces a fresh press.
- Reset values: s1, s2, level, press, release, rpt, dbc, rc = 0; FSM = IDLE. A button held through reset produces a press after release of reset.

## Timing
- raw change set up before edge E0: s2 changes at E1, level/press/release at E(DB_CYCLES+1), i.e. latency DB_CYCLES+2 edges.
- Auto-repeat on press at cycle P: rpt at P, P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_RATE, then every REPEAT_RATE.
- press and release are never high together on one channel; strobes are always exactly one cycle wide.
- Channels are fully independent; simultaneous events on all channels are all reported in the same cycle.
- Counters saturate-free: rc never exceeds max(REPEAT_DELAY, REPEAT_RATE); no wrap occurs.
- Reset mid-operation clears all outputs asynchronously within the same cycle; no strobe is emitted on reset deassertion.

## Test plan
- Default params, raw_in[3] (active-high) 0→1 held: level[3] and press[3] rise 6 edges later; press[3] high exactly 1 cycle.
- raw_in[0] (active-low) 1→0 glitches for 3 cycles then returns to 1: level[0] never rises; no press/release/rpt.
- Hold channel 0 for 40 cycles after press at P: rpt[0] at P, P+20, P+25, P+30, P+35; release strobe 6 edges after raw release; no rpt after release.
- Hold channel 2 (unmasked) for 40 cycles: rpt[2] only at press cycle.
- Assert flush while channel 1 is held in RUN: all outputs 0 next cycle; a new press[1] comes DB_CYCLES cycles later; the repeat schedule restarts.
- Assert reset asynchronously mid-ARM with all 6 buttons held: outputs 0 immediately; after deassertion, all six press strobes fire in the same cycle, 6 edges later.

Source files
------------

// File: rtl/game_input_bank.sv
// Per-channel button conditioner: polarity fix, 2-flop sync, debounce, edge strobes and auto-repeat.
// The release strobe port is named release_o because "release" is a reserved SystemVerilog keyword.
module game_input_bank #(
    parameter int                N_CH            = 6,
    parameter logic [N_CH-1:0]   ACTIVE_LOW_MASK = 6'b000111,
    parameter int                DB_CYCLES       = 4,
    parameter logic [N_CH-1:0]   REPEAT_MASK     = 6'b011011,
    parameter int                REPEAT_DELAY    = 20,
    parameter int                REPEAT_RATE     = 5
) (
    input  logic            clk_game,
    input  logic            reset,
    input  logic            flush,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] rpt
);

    localparam int DBW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW    = $clog2(RC_MAX + 1);

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RATE_LAST  = RCW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_ARM  = 2'd1,
        RS_RUN  = 2'd2
    } rpt_state_e;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam bit MASKED = REPEAT_MASK[i];

        logic            s1_q, s2_q;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            rel_q, rel_d;
        logic            rpt_q, rpt_d;
        logic [DBW-1:0]  dbc_q, dbc_d;
        logic [RCW-1:0]  rc_q, rc_d;
        rpt_state_e      st_q, st_d;
        logic            rise, fall, auto_pulse;

        always_comb begin
            level_d    = level_q;
            dbc_d      = dbc_q;
            rise       = 1'b0;
            fall       = 1'b0;
            st_d       = st_q;
            rc_d       = rc_q;
            auto_pulse = 1'b0;

            if (s2_q == level_q) begin
                dbc_d = '0;
            end else if (dbc_q == DB_LAST) begin
                level_d = s2_q;
                dbc_d   = '0;
                rise    = s2_q;
                fall    = ~s2_q;
            end else begin
                dbc_d = dbc_q + 1'b1;
            end

            // A falling level always wins so no repeat pulse can coincide with release.
            if (MASKED) begin
                if (fall) begin
                    st_d = RS_IDLE;
                    rc_d = '0;
                end else begin
                    case (st_q)
                        RS_IDLE: begin
                            if (rise) begin
                                st_d = RS_ARM;
                                rc_d = '0;
                            end
                        end
                        RS_ARM: begin
                            if (rc_q == DELAY_LAST) begin
                                auto_pulse = 1'b1;
                                st_d       = RS_RUN;
                                rc_d       = '0;
                            end else begin
                                rc_d = rc_q + 1'b1;
                            end
                        end
                        RS_RUN: begin
                            if (rc_q == RATE_LAST) begin
                                auto_pulse = 1'b1;
                                rc_d       = '0;
                            end else begin
                                rc_d = rc_q + 1'b1;
                            end
                        end
                        default: begin
                            st_d = RS_IDLE;
                            rc_d = '0;
                        end
                    endcase
                end
            end

            press_d = rise;
            rel_d   = fall;
            rpt_d   = rise | auto_pulse;

            // Flush leaves the synchronisers alone so a held button re-debounces from s2.
            if (flush) begin
                level_d = 1'b0;
                dbc_d   = '0;
                rc_d    = '0;
                st_d    = RS_IDLE;
                press_d = 1'b0;
                rel_d   = 1'b0;
                rpt_d   = 1'b0;
            end
        end

        always_ff @(posedge clk_game or posedge reset) begin
            if (reset) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                level_q <= 1'b0;
                dbc_q   <= '0;
                rc_q    <= '0;
                st_q    <= RS_IDLE;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                rpt_q   <= 1'b0;
            end else begin
                s1_q    <= raw_in[i] ^ ACTIVE_LOW_MASK[i];
                s2_q    <= s1_q;
                level_q <= level_d;
                dbc_q   <= dbc_d;
                rc_q    <= rc_d;
                st_q    <= st_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                rpt_q   <= rpt_d;
            end
        end

        assign level[i]     = level_q;
        assign press[i]     = press_q;
        assign release_o[i] = rel_q;
        assign rpt[i]       = rpt_q;
    end

endmodule
